sc_window_accumulator: RTL and testbench
========================================

SC_WINDOW_ACCUMULATOR -- requirements
Module: sc_window_accumulator

Interface
REQ-001 SHALL provide parameter LOG2_WIN, default 4, meaning log2 of the number of 8-bit windows per frame (N = 2^LOG2_WIN, legal range 1..6).
REQ-002 SHALL provide port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL provide port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL provide port in_valid  input  1  one-cycle strobe marking a new window result from the stochastic multiplier stage.
REQ-005 SHALL provide port in_count  input  3  number of 1s in the window, modulo 8.
REQ-006 SHALL provide port in_ovf  input  1  window wrap flag; {in_ovf,in_count} forms the 4-bit window count.
REQ-007 SHALL provide port sync  input  1  discards the partial frame and restarts window counting.
REQ-008 SHALL provide port out_valid  output  1  result register holds an unconsumed frame.
REQ-009 SHALL provide port out_ready  input  1  consumer accepts result when high with out_valid.
REQ-010 SHALL provide port out_sum  output  LOG2_WIN+4  unsigned total of window counts in the frame.
REQ-011 SHALL provide port out_bipolar  output  LOG2_WIN+5  signed two's complement bipolar value, 2*out_sum - 8*N.
REQ-012 SHALL provide port in_err  output  1  sticky flag: an illegal window count was received.
REQ-013 SHALL provide port drop_cnt  output  8  saturating count of completed frames lost due to back-pressure.

Function
REQ-014 SHALL form window count w = {in_ovf,in_count}; w > 8 SHALL be clamped to 8 and SHALL set in_err.
REQ-015 SHALL, on each in_valid cycle, add w to the accumulator and increment the window counter (LOG2_WIN bits, wraps 2^LOG2_WIN-1 -> 0).
REQ-016 SHALL, when the accepted window is the N-th of the frame, compute the frame total including that window and clear the accumulator for the next cycle.
REQ-017 SHALL load the frame total into the result register one cycle after the N-th in_valid if the register is empty or is being consumed (out_valid && out_ready) in that same cycle.
REQ-018 SHALL otherwise discard the completed frame, leave the result register unchanged, and increment drop_cnt, holding at 255.
REQ-019 SHALL clear out_valid on a cycle with out_valid && out_ready and no simultaneous load; load wins over clear.
REQ-020 SHALL keep out_sum and out_bipolar stable while out_valid is high and not consumed.
REQ-021 SHALL, on sync without in_valid, zero the accumulator and window counter; the result register, drop_cnt and in_err are unaffected.
REQ-022 SHALL, on sync with in_valid in the same cycle, discard the partial frame and count the current w as window 1 of the new frame.
REQ-023 SHALL ignore in_count and in_ovf on cycles with in_valid low.
REQ-024 SHALL accept in_valid on consecutive cycles with no throughput loss; the accumulator SHALL never overflow (max 8*N fits LOG2_WIN+4 bits).
REQ-025 SHALL compute out_bipolar from the registered out_sum with no added latency.

Reset
REQ-026 SHALL, while rst_n is low, hold accumulator = 0, window counter = 0, out_valid = 0, out_sum = 0, out_bipolar = -8*N, in_err = 0, drop_cnt = 0.
REQ-027 SHALL abandon any partial frame on reset mid-operation; first frame after release starts at the first in_valid.
REQ-028 SHALL leave reset on the first rising clk edge after rst_n goes high with no spurious out_valid.

Verification (LOG2_WIN=2, N=4)
REQ-029 SHALL cover: four back-to-back in_valid with w=8,8,8,8, out_ready=1 -> out_valid next cycle, out_sum=32, out_bipolar=+32.
REQ-030 SHALL cover: windows w=4,4,4,4 -> out_sum=16, out_bipolar=0; windows w=0 x4 -> out_sum=0, out_bipolar=-32.
REQ-031 SHALL cover: out_ready=0, two full frames (sums 10 then 20) -> out_sum stays 10, drop_cnt=1; then out_ready=1 -> out_valid falls.
REQ-032 SHALL cover: in_ovf=1, in_count=3 (w=11) -> counted as 8, in_err=1 and stays 1 until reset.
REQ-033 SHALL cover: two windows w=5, then sync with in_valid w=2, then three windows w=1 -> out_sum=5, not 15.
REQ-034 SHALL cover: rst_n low after three windows, then four windows w=2 -> out_sum=8, drop_cnt=0, out_valid only after the fourth.

Source files
------------

// File: rtl/sc_window_accumulator.sv
// Sums 2^LOG2_WIN stochastic window counts per frame into an unsigned total and a bipolar value.
// Result is valid the cycle after the last window; a frame finishing while the result is still held and not consumed is dropped and counted.
module sc_window_accumulator #(
    parameter int LOG2_WIN = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [2:0]            in_count,
    input  logic                  in_ovf,
    input  logic                  sync,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [LOG2_WIN+3:0]   out_sum,
    output logic signed [LOG2_WIN+4:0] out_bipolar,
    output logic                  in_err,
    output logic [7:0]            drop_cnt
);
    localparam int N  = 1 << LOG2_WIN;
    localparam int SW = LOG2_WIN + 4;
    localparam int BW = LOG2_WIN + 5;

    logic [SW-1:0]       acc_q, acc_d;
    logic [LOG2_WIN-1:0] win_q, win_d;
    logic                out_valid_q, out_valid_d;
    logic [SW-1:0]       out_sum_q, out_sum_d;
    logic                in_err_q, in_err_d;
    logic [7:0]          drop_q, drop_d;

    logic [3:0]    w_raw;
    logic [3:0]    w;
    logic          last_win;
    logic          frame_done;
    logic [SW-1:0] frame_sum;
    logic [BW-1:0] bip_u;

    assign w_raw      = {in_ovf, in_count};
    assign w          = (w_raw > 4'd8) ? 4'd8 : w_raw;
    assign last_win   = (win_q == {LOG2_WIN{1'b1}});
    assign frame_sum  = acc_q + SW'(w);
    // sync restarts the frame, so a window arriving with it can never complete one
    assign frame_done = in_valid && !sync && last_win;

    always_comb begin
        acc_d       = acc_q;
        win_d       = win_q;
        out_valid_d = out_valid_q;
        out_sum_d   = out_sum_q;
        in_err_d    = in_err_q;
        drop_d      = drop_q;

        if (in_valid) begin
            if (w_raw > 4'd8) begin
                in_err_d = 1'b1;
            end
            if (sync) begin
                acc_d = SW'(w);
                win_d = LOG2_WIN'(1);
            end else if (last_win) begin
                acc_d = '0;
                win_d = '0;
            end else begin
                acc_d = frame_sum;
                win_d = win_q + LOG2_WIN'(1);
            end
        end else if (sync) begin
            acc_d = '0;
            win_d = '0;
        end

        if (frame_done && (!out_valid_q || out_ready)) begin
            out_valid_d = 1'b1;
            out_sum_d   = frame_sum;
        end else begin
            if (frame_done && (drop_q != 8'hFF)) begin
                drop_d = drop_q + 8'd1;
            end
            if (out_valid_q && out_ready) begin
                out_valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q       <= '0;
            win_q       <= '0;
            out_valid_q <= 1'b0;
            out_sum_q   <= '0;
            in_err_q    <= 1'b0;
            drop_q      <= '0;
        end else begin
            acc_q       <= acc_d;
            win_q       <= win_d;
            out_valid_q <= out_valid_d;
            out_sum_q   <= out_sum_d;
            in_err_q    <= in_err_d;
            drop_q      <= drop_d;
        end
    end

    assign bip_u       = {out_sum_q, 1'b0} - BW'(8 * N);
    assign out_bipolar = $signed(bip_u);
    assign out_valid   = out_valid_q;
    assign out_sum     = out_sum_q;
    assign in_err      = in_err_q;
    assign drop_cnt    = drop_q;
endmodule

// File: tb/tb_sc_window_accumulator.sv
// Bench for sc_window_accumulator with four windows per frame.
module tb_sc_window_accumulator;
    localparam int L = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [2:0]        in_count;
    logic              in_ovf;
    logic              sync;
    logic              out_valid;
    logic              out_ready;
    logic [L+3:0]      out_sum;
    logic signed [L+4:0] out_bipolar;
    logic              in_err;
    logic [7:0]        drop_cnt;

    sc_window_accumulator #(.LOG2_WIN(L)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_count(in_count),
        .in_ovf(in_ovf), .sync(sync), .out_valid(out_valid), .out_ready(out_ready),
        .out_sum(out_sum), .out_bipolar(out_bipolar), .in_err(in_err), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // reference: frame contents held as a list of clamped window counts
    int mq[$];
    bit m_vld;
    int m_sum;
    int m_drop;
    bit m_err;

    task automatic chk(string nm, int act, int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
        end
    endtask

    task automatic model_step();
        bit consumed;
        bit load;
        int wv;
        int s;
        consumed = m_vld && out_ready;
        load = 1'b0;
        if (in_valid) begin
            wv = int'({in_ovf, in_count});
            if (wv > 8) begin
                m_err = 1'b1;
                wv = 8;
            end
            if (sync) mq.delete();
            mq.push_back(wv);
            if (mq.size() == (1 << L)) begin
                s = 0;
                foreach (mq[k]) s += mq[k];
                mq.delete();
                if (!m_vld || out_ready) begin
                    load = 1'b1;
                    m_vld = 1'b1;
                    m_sum = s;
                end else if (m_drop < 255) begin
                    m_drop++;
                end
            end
        end else if (sync) begin
            mq.delete();
        end
        if (!load && consumed) m_vld = 1'b0;
    endtask

    task automatic drive(bit v, logic [3:0] raw, bit s, bit r);
        in_valid  = v;
        in_count  = raw[2:0];
        in_ovf    = raw[3];
        sync      = s;
        out_ready = r;
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_model();
        chk("rnd_valid", int'(out_valid), int'(m_vld));
        chk("rnd_sum", int'(out_sum), m_sum);
        chk("rnd_bipolar", int'(out_bipolar), 2 * m_sum - 8 * (1 << L));
        chk("rnd_drop", int'(drop_cnt), m_drop);
        chk("rnd_err", int'(in_err), int'(m_err));
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0; in_count = '0; in_ovf = 1'b0; sync = 1'b0; out_ready = 1'b0;
        mq.delete();
        m_vld = 1'b0; m_sum = 0; m_drop = 0; m_err = 1'b0;
        #2;
        chk("rst_valid", int'(out_valid), 0);
        chk("rst_sum", int'(out_sum), 0);
        chk("rst_bipolar", int'(out_bipolar), -32);
        chk("rst_err", int'(in_err), 0);
        chk("rst_drop", int'(drop_cnt), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_valid", int'(out_valid), 0);
    endtask

    typedef struct {
        logic [3:0][3:0] ws;
        int              sum;
        int              bip;
        int              err;
    } vec_t;

    vec_t tbl[6];

    initial begin
        tbl[0] = '{ws: {4'd8, 4'd8, 4'd8, 4'd8}, sum: 32, bip: 32,  err: 0};
        tbl[1] = '{ws: {4'd4, 4'd4, 4'd4, 4'd4}, sum: 16, bip: 0,   err: 0};
        tbl[2] = '{ws: {4'd0, 4'd0, 4'd0, 4'd0}, sum: 0,  bip: -32, err: 0};
        tbl[3] = '{ws: {4'd4, 4'd3, 4'd2, 4'd1}, sum: 10, bip: -12, err: 0};
        tbl[4] = '{ws: {4'd1, 4'd7, 4'd0, 4'd8}, sum: 16, bip: 0,   err: 0};
        tbl[5] = '{ws: {4'd0, 4'd0, 4'd0, 4'd11}, sum: 8, bip: -16, err: 1};

        do_reset();

        // frames back to back with the consumer always ready
        foreach (tbl[i]) begin
            for (int k = 0; k < 4; k++) begin
                if (k == 3) chk($sformatf("tbl%0d_early_valid", i), int'(out_valid), 0);
                drive(1'b1, tbl[i].ws[k], 1'b0, 1'b1);
            end
            chk($sformatf("tbl%0d_valid", i), int'(out_valid), 1);
            chk($sformatf("tbl%0d_sum", i), int'(out_sum), tbl[i].sum);
            chk($sformatf("tbl%0d_bipolar", i), int'(out_bipolar), tbl[i].bip);
            chk($sformatf("tbl%0d_err", i), int'(in_err), tbl[i].err);
            drive(1'b0, 4'd0, 1'b0, 1'b1);
            chk($sformatf("tbl%0d_consumed", i), int'(out_valid), 0);
        end
        drive(1'b0, 4'd0, 1'b0, 1'b0);
        chk("err_sticky", int'(in_err), 1);

        // back-pressure: second frame is dropped, first one held
        do_reset();
        for (int k = 1; k <= 4; k++) drive(1'b1, 4'(k), 1'b0, 1'b0);
        chk("bp_first_valid", int'(out_valid), 1);
        chk("bp_first_sum", int'(out_sum), 10);
        for (int k = 0; k < 4; k++) drive(1'b1, 4'd5, 1'b0, 1'b0);
        chk("bp_hold_sum", int'(out_sum), 10);
        chk("bp_hold_valid", int'(out_valid), 1);
        chk("bp_drop", int'(drop_cnt), 1);
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        chk("bp_release", int'(out_valid), 0);

        // drop counter saturates
        for (int f = 0; f < 260; f++)
            for (int k = 0; k < 4; k++) drive(1'b1, 4'd1, 1'b0, 1'b0);
        chk("drop_sat", int'(drop_cnt), 255);
        chk("drop_sat_sum", int'(out_sum), 4);

        // sync together with a window starts a new frame at that window
        do_reset();
        drive(1'b1, 4'd5, 1'b0, 1'b1);
        drive(1'b1, 4'd5, 1'b0, 1'b1);
        drive(1'b1, 4'd2, 1'b1, 1'b1);
        drive(1'b1, 4'd1, 1'b0, 1'b1);
        drive(1'b1, 4'd1, 1'b0, 1'b1);
        chk("sync_v_early", int'(out_valid), 0);
        drive(1'b1, 4'd1, 1'b0, 1'b1);
        chk("sync_v_valid", int'(out_valid), 1);
        chk("sync_v_sum", int'(out_sum), 5);

        // sync alone discards partial frame; result untouched
        drive(1'b1, 4'd3, 1'b0, 1'b0);
        drive(1'b1, 4'd3, 1'b0, 1'b0);
        drive(1'b0, 4'd7, 1'b1, 1'b0);
        chk("sync_keep_sum", int'(out_sum), 5);
        chk("sync_keep_valid", int'(out_valid), 1);
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) drive(1'b1, 4'd1, 1'b0, 1'b1);
        chk("sync_only_sum", int'(out_sum), 4);
        chk("sync_only_drop", int'(drop_cnt), 0);

        // reset mid-frame abandons the partial frame
        drive(1'b0, 4'd0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) drive(1'b1, 4'd2, 1'b0, 1'b1);
        do_reset();
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) drive(1'b1, 4'd2, 1'b0, 1'b1);
        chk("rst_mid_early", int'(out_valid), 0);
        drive(1'b1, 4'd2, 1'b0, 1'b1);
        chk("rst_mid_valid", int'(out_valid), 1);
        chk("rst_mid_sum", int'(out_sum), 8);
        chk("rst_mid_drop", int'(drop_cnt), 0);

        // randomized traffic against the reference
        do_reset();
        for (int c = 0; c < 600; c++) begin
            logic [3:0] raw;
            raw = ($urandom_range(0, 19) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
            drive($urandom_range(0, 3) != 0, raw, $urandom_range(0, 24) == 0, $urandom_range(0, 2) != 0);
            check_model();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
